// File: rtl/audio_adc_i2s_rx.sv
// I2S capture receiver for the codec ADC path: oversamples BCLK/ADCLRCK/ADCDAT,
// deserializes left/right words and queues stereo pairs in a FWFT FIFO.
module audio_adc_i2s_rx #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_50_clk,
    input  logic                          reset_reset,
    input  logic                          enable,
    input  logic                          clear_status,
    input  logic                          audio_in_BCLK,
    input  logic                          audio_in_ADCLRCK,
    input  logic                          audio_in_ADCDAT,
    output logic [2*DATA_WIDTH-1:0]       out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    output logic                          short_frame
);

    // state     | meaning
    // WAIT_EDGE | idle or resyncing; waits for an LRCK change before capturing
    // CAPTURE   | aligned to LRCK; shifting words and pushing pairs
    typedef enum logic {WAIT_EDGE, CAPTURE} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(DATA_WIDTH + 2);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(DATA_WIDTH);
    localparam logic [SW-1:0] SLOT_MAX   = SW'(DATA_WIDTH + 1);
    localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(FIFO_DEPTH);

    state_t                  state_q, state_d;
    logic [1:0]              bclk_sync, lrck_sync, dat_sync;
    logic                    bclk_prev;
    logic                    rise, lrck, dat;
    logic                    lrck_last, lrck_seen, lrck_change;
    logic [SW-1:0]           slot_q, slot_now;
    logic [DATA_WIDTH-1:0]   shreg, left_hold, word_now;
    logic                    left_ok;
    logic                    shift_en, left_done, push, short_set;

    logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [AW:0]             count;
    logic                    pop, full, wr_en, drop;

    always_ff @(posedge clk_50_clk) begin
        if (reset_reset) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[0], audio_in_BCLK};
            lrck_sync <= {lrck_sync[0], audio_in_ADCLRCK};
            dat_sync  <= {dat_sync[0], audio_in_ADCDAT};
            bclk_prev <= bclk_sync[1];
        end
    end

    assign rise     = bclk_sync[1] & ~bclk_prev;
    assign lrck     = lrck_sync[1];
    assign dat      = dat_sync[1];
    assign word_now = {shreg[DATA_WIDTH-2:0], dat};

    // The first rise after reset only learns the LRCK level, so a reset taken
    // mid-channel cannot masquerade as a channel boundary.
    assign lrck_change = lrck_seen && (lrck != lrck_last);
    assign slot_now    = (!lrck_seen || lrck_change) ? '0 :
                         (slot_q == SLOT_MAX) ? SLOT_MAX : slot_q + SW'(1);

    always_comb begin
        state_d   = state_q;
        shift_en  = 1'b0;
        left_done = 1'b0;
        push      = 1'b0;
        short_set = 1'b0;
        case (state_q)
            WAIT_EDGE: begin
                if (enable && rise && lrck_change)
                    state_d = CAPTURE;
            end
            CAPTURE: begin
                if (!enable) begin
                    state_d = WAIT_EDGE;
                end else if (rise) begin
                    if (lrck_change) begin
                        if (slot_q >= SW'(1) && slot_q < SLOT_LAST)
                            short_set = 1'b1;
                    end else if (slot_now <= SLOT_LAST) begin
                        shift_en = 1'b1;
                        if (slot_now == SLOT_LAST) begin
                            if (!lrck)
                                left_done = 1'b1;
                            else if (left_ok)
                                push = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_50_clk) begin
        if (reset_reset) begin
            state_q   <= WAIT_EDGE;
            slot_q    <= '0;
            lrck_last <= 1'b0;
            lrck_seen <= 1'b0;
            shreg     <= '0;
            left_hold <= '0;
            left_ok   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (rise) begin
                lrck_last <= lrck;
                lrck_seen <= 1'b1;
                slot_q    <= slot_now;
            end
            if (shift_en)
                shreg <= word_now;
            if (left_done)
                left_hold <= word_now;
            if (state_q != CAPTURE || !enable || short_set || push)
                left_ok <= 1'b0;
            else if (left_done)
                left_ok <= 1'b1;
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop   = out_valid & out_ready;
    assign full  = (count == LEVEL_FULL);
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_ff @(posedge clk_50_clk) begin
        if (wr_en)
            mem[wr_ptr] <= {left_hold, word_now};
    end

    always_ff @(posedge clk_50_clk) begin
        if (reset_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_50_clk) begin
        if (reset_reset) begin
            overrun     <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            if (drop)
                overrun <= 1'b1;
            else if (clear_status)
                overrun <= 1'b0;
            if (short_set)
                short_frame <= 1'b1;
            else if (clear_status)
                short_frame <= 1'b0;
        end
    end

    assign out_valid  = (count != '0);
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign fifo_level = count;

endmodule

// File: tb/tb_audio_adc_i2s_rx.sv
// Self-checking bench for audio_adc_i2s_rx: drives I2S frames and checks the
// popped pairs, level and sticky flags against a queue-based expectation.
module tb_audio_adc_i2s_rx;
    localparam int DW = 16;
    localparam int FD = 4;

    logic            clk = 1'b0;
    logic            reset_reset, enable, clear_status;
    logic            audio_in_BCLK, audio_in_ADCLRCK, audio_in_ADCDAT;
    logic [2*DW-1:0] out_data;
    logic            out_valid, out_ready;
    logic [2:0]      fifo_level;
    logic            overrun, short_frame;

    int              checks = 0;
    int              errors = 0;
    logic [2*DW-1:0] model_q[$];
    bit              exp_overrun = 0;
    int              bhalf = 8;

    typedef struct {
        logic [DW-1:0] left;
        logic [DW-1:0] right;
        int            slots;
        int            half;
        bit            exp_push;
    } vec_t;
    vec_t vecs[8];

    audio_adc_i2s_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .clk_50_clk(clk), .reset_reset(reset_reset), .enable(enable),
        .clear_status(clear_status), .audio_in_BCLK(audio_in_BCLK),
        .audio_in_ADCLRCK(audio_in_ADCLRCK), .audio_in_ADCDAT(audio_in_ADCDAT),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_level(fifo_level), .overrun(overrun), .short_frame(short_frame)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A pair enters the FIFO if there is room or the head leaves in the same cycle.
    task automatic model_push(input logic [2*DW-1:0] pair);
        if (model_q.size() < FD || out_ready)
            model_q.push_back(pair);
        else
            exp_overrun = 1;
    endtask

    always @(negedge clk) begin
        if (!reset_reset && out_valid && out_ready) begin
            if (model_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected no pair", out_data);
            end else begin
                chk("pop_data", out_data, model_q[0]);
                void'(model_q.pop_front());
            end
        end
    end

    function automatic logic bit_of(input logic [DW-1:0] w, input int s);
        if (s >= 1 && s <= DW)
            return w[DW-s];
        return 1'($urandom_range(0, 1));
    endfunction

    // mode 1: latency probe around the final bit; mode 2: pop pulse coinciding with the push
    task automatic bclk_cycle(input logic lr, input logic d, input int mode,
                              input bit push, input logic [2*DW-1:0] pair);
        audio_in_BCLK    = 1'b0;
        audio_in_ADCLRCK = lr;
        audio_in_ADCDAT  = d;
        repeat (bhalf) tick();
        audio_in_BCLK = 1'b1;
        tick();
        tick();
        if (mode == 1) chk("lat_edge1_valid", out_valid, 0);
        if (mode == 2) out_ready = 1'b1;
        if (push) model_push(pair);
        tick();
        if (mode == 1) begin
            chk("lat_edge2_valid", out_valid, 1);
            chk("lat_edge2_data", out_data, pair);
        end
        if (mode == 2) begin
            out_ready = 1'b0;
            chk("simul_level", fifo_level, 4);
            chk("simul_overrun", overrun, 0);
        end
        tick();
        if (mode == 1) chk("lat_one_cycle", out_valid, 0);
        repeat ((bhalf > 4) ? bhalf - 4 : 0) tick();
    endtask

    task automatic send_channel(input logic lr, input logic [DW-1:0] word, input int n,
                                input int mode, input bit push, input logic [2*DW-1:0] pair);
        for (int s = 0; s < n; s++)
            bclk_cycle(lr, bit_of(word, s), (s == DW) ? mode : 0, push && (s == DW), pair);
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int n,
                              input int mode, input bit push);
        send_channel(1'b0, l, n, 0, 1'b0, '0);
        send_channel(1'b1, r, n, mode, push, {l, r});
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd();
        return DW'($urandom);
    endfunction

    initial begin
        logic [DW-1:0] wa, wb;
        logic [DW-1:0] bp_l[5], bp_r[5];

        vecs[0] = '{16'hA5C3, 16'h3C5A, 32, 8, 1'b1};
        vecs[1] = '{rnd(), rnd(), DW + 1, 8, 1'b1};
        vecs[2] = '{rnd(), rnd(), DW + 1, 2, 1'b1};
        for (int i = 3; i < 8; i++)
            vecs[i] = '{rnd(), rnd(), int'($urandom_range(DW + 1, 32)), int'($urandom_range(2, 8)), 1'b1};
        for (int i = 0; i < 8; i++)
            vecs[i].exp_push = (vecs[i].slots >= DW + 1);

        reset_reset = 1'b1; enable = 1'b1; clear_status = 1'b0; out_ready = 1'b1;
        audio_in_BCLK = 1'b0; audio_in_ADCLRCK = 1'b0; audio_in_ADCDAT = 1'b0;
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_data", out_data, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_short", short_frame, 0);
        reset_reset = 1'b0;

        send_channel(1'b1, '0, DW + 2, 0, 1'b0, '0);

        for (int i = 0; i < 8; i++) begin
            bhalf = vecs[i].half;
            send_frame(vecs[i].left, vecs[i].right, vecs[i].slots, (i == 0) ? 1 : 0, vecs[i].exp_push);
        end
        bhalf = 8;
        repeat (40) tick();
        chk("table_drained", model_q.size(), 0);
        chk("table_short", short_frame, 0);
        chk("table_overrun", overrun, 0);

        send_frame(rnd(), rnd(), 12, 0, 1'b0);
        chk("short_flag", short_frame, 1);
        chk("short_level", fifo_level, 0);
        send_frame(rnd(), rnd(), 32, 0, 1'b1);
        repeat (40) tick();
        chk("short_recover", model_q.size(), 0);
        pulse_clear();
        chk("short_cleared", short_frame, 0);

        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bp_l[i] = rnd();
            bp_r[i] = rnd();
            send_frame(bp_l[i], bp_r[i], 32, 0, 1'b1);
        end
        chk("bp_level", fifo_level, 4);
        chk("bp_overrun", overrun, exp_overrun);
        chk("bp_head", out_data, {bp_l[0], bp_r[0]});
        out_ready = 1'b1;
        repeat (20) tick();
        chk("bp_drained", model_q.size(), 0);
        chk("bp_level_empty", fifo_level, 0);
        chk("bp_overrun_sticky", overrun, 1);
        pulse_clear();
        exp_overrun = 0;
        chk("bp_overrun_cleared", overrun, 0);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send_frame(rnd(), rnd(), 32, 0, 1'b1);
        chk("simul_fill", fifo_level, 4);
        send_frame(rnd(), rnd(), 32, 2, 1'b1);
        chk("simul_overrun_after", overrun, exp_overrun);
        out_ready = 1'b1;
        repeat (20) tick();
        chk("simul_drained", model_q.size(), 0);

        out_ready = 1'b0;
        send_frame(rnd(), rnd(), 32, 0, 1'b1);
        chk("prerst_level", fifo_level, 1);
        wa = rnd();
        for (int s = 0; s <= 8; s++)
            bclk_cycle(1'b0, bit_of(wa, s), 0, 1'b0, '0);
        reset_reset = 1'b1;
        model_q.delete();
        exp_overrun = 0;
        tick();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_level", fifo_level, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_short", short_frame, 0);
        reset_reset = 1'b0;
        for (int s = 9; s < 32; s++)
            bclk_cycle(1'b0, bit_of(wa, s), 0, 1'b0, '0);
        send_channel(1'b1, rnd(), 32, 0, 1'b0, '0);
        out_ready = 1'b1;
        send_frame(rnd(), rnd(), 32, 0, 1'b1);
        repeat (20) tick();
        chk("midrst_first_pair", model_q.size(), 0);

        enable = 1'b0;
        for (int i = 0; i < 3; i++)
            send_frame(rnd(), rnd(), 32, 0, 1'b0);
        chk("dis_level", fifo_level, 0);
        chk("dis_valid", out_valid, 0);
        send_channel(1'b0, rnd(), 32, 0, 1'b0, '0);
        wb = rnd();
        for (int s = 0; s < 32; s++) begin
            if (s == 8) enable = 1'b1;
            bclk_cycle(1'b1, bit_of(wb, s), 0, 1'b0, '0);
        end
        chk("en_mid_right_dropped", fifo_level, 0);
        send_frame(rnd(), rnd(), 32, 0, 1'b1);
        repeat (20) tick();
        chk("en_next_frame", model_q.size(), 0);
        chk("final_overrun", overrun, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
